// File: rtl/cnt_ctrl_pkg.sv
// Shared types and default widths for the counter enable generator.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STEP} gen_state_t;

  localparam int PRESCALE_W_DEF = 8;
  localparam int BURST_W_DEF    = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-(div_q+1) prescaler; tc marks the terminal count
// while enabled and the counter wraps to zero on that same edge.
module tick_prescaler
  import cnt_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] div_q,
  output logic                  tc
);

  logic [PRESCALE_W-1:0] pre_cnt;

  assign tc = enable && (pre_cnt == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= (pre_cnt == div_q) ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_enable_gen.sv
// Toggle-enable generator for the 4-bit T-flip-flop counter: continuous run,
// fixed-length bursts or single steps, each pulse exactly one cycle wide.
module count_enable_gen
  import cnt_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BURST_W    = BURST_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic [PRESCALE_W-1:0] div,
  input  logic [BURST_W-1:0]    burst_len,
  output logic                  t_en,
  output logic                  done,
  output logic                  busy
);

  // Handshake: start/stop/step are plain levels sampled on every rising
  // edge; t_en and done are registered strobes valid for one cycle only.
  gen_state_t            state;
  logic [PRESCALE_W-1:0] div_q;
  logic [BURST_W-1:0]    len_q;
  logic [BURST_W-1:0]    tick_cnt;
  logic [BURST_W-1:0]    last_tick;
  logic                  pre_clear;
  logic                  pre_enable;
  logic                  pre_tc;

  assign busy       = (state != IDLE);
  assign last_tick  = len_q - 1'b1;
  assign pre_clear  = (state == IDLE) && start;
  assign pre_enable = (state == RUN);

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (pre_clear),
    .enable (pre_enable),
    .div_q  (div_q),
    .tc     (pre_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      t_en     <= 1'b0;
      done     <= 1'b0;
      div_q    <= '0;
      len_q    <= '0;
      tick_cnt <= '0;
    end else begin
      t_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            div_q    <= div;
            len_q    <= burst_len;
            tick_cnt <= '0;
          end else if (step) begin
            state <= STEP;
          end
        end
        RUN: begin
          // A stop wins over a coincident terminal count: no pulse is issued.
          if (stop) begin
            state <= IDLE;
          end else if (pre_tc) begin
            t_en <= 1'b1;
            if (len_q != '0) begin
              if (tick_cnt == last_tick) begin
                done     <= 1'b1;
                state    <= IDLE;
                tick_cnt <= '0;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
        end
        STEP: begin
          t_en  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_enable_gen.sv
// Scoreboard bench for count_enable_gen: a pulse-schedule model predicts the
// edge of every t_en pulse and its done flag; a monitor pops and compares.
module tb_count_enable_gen;

  localparam int PW    = 8;
  localparam int BW    = 8;
  localparam int NEVER = 32'h3fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          step = 1'b0;
  logic [PW-1:0] div = '0;
  logic [BW-1:0] burst_len = '0;
  logic          t_en;
  logic          done;
  logic          busy;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            free_edge = -1;
  bit            in_run = 1'b0;
  int            pulse_cnt = 0;
  logic [3:0]    cnt4 = '0;
  // Entry layout: {edge index of the pulse, expected done flag}
  logic [32:0]   exp_q[$];

  always #5 clk = ~clk;

  count_enable_gen #(
    .PRESCALE_W(PW),
    .BURST_W   (BW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .div       (div),
    .burst_len (burst_len),
    .t_en      (t_en),
    .done      (done),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a run started at edge E with divisor D schedules pulse k
  // at edge E + k*(D+1); the generator is occupied until its last scheduled edge.
  always @(posedge clk) begin
    int d;
    int l;
    int k;
    if (rst_n) begin
      cyc = cyc + 1;
      if (in_run && cyc <= free_edge) begin
        if (stop) begin
          while (exp_q.size() > 0 && int'(exp_q[$][32:1]) >= cyc) void'(exp_q.pop_back());
          free_edge = cyc;
          in_run    = 1'b0;
        end
      end else if (cyc > free_edge) begin
        in_run = 1'b0;
        if (start) begin
          d = int'(div);
          l = int'(burst_len);
          k = 1;
          while ((l != 0 && k <= l) || (l == 0 && k * (d + 1) <= 600)) begin
            exp_q.push_back({32'(cyc + k * (d + 1)), (k == l)});
            k++;
          end
          free_edge = (l == 0) ? NEVER : cyc + l * (d + 1);
          in_run    = 1'b1;
        end else if (step) begin
          exp_q.push_back({32'(cyc + 1), 1'b0});
          free_edge = cyc + 1;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    in_run    = 1'b0;
    free_edge = cyc;
  end

  // Monitor: at each falling edge the outputs reflect edge number cyc.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      while (exp_q.size() > 0 && int'(exp_q[0][32:1]) < cyc) begin
        e = exp_q.pop_front();
        check("missed_pulse_edge", cyc, e[32:1]);
      end
      if (t_en) begin
        pulse_cnt++;
        cnt4 = cnt4 + 4'd1;
      end
      if (exp_q.size() > 0 && int'(exp_q[0][32:1]) == cyc) begin
        e = exp_q.pop_front();
        check("t_en_expected", t_en, 1);
        check("done_flag", done, t_en ? e[0] : 1'b0);
      end else begin
        check("t_en_unexpected", t_en, 0);
        check("done_idle", done, 0);
      end
      check("busy", busy, (cyc < free_edge) ? 1 : 0);
    end
  end

  task automatic drive(input logic s, input logic t, input logic p);
    @(negedge clk);
    start = s;
    step  = t;
    stop  = p;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int p0;
    int pick;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_t_en", t_en, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Continuous run, period 4; a 4-bit counter wraps after 16 pulses
    div = 8'd3; burst_len = 8'd0; cnt4 = '0;
    p0 = pulse_cnt;
    drive(1, 0, 0);
    idle(65);
    #1;
    check("cont_pulses", pulse_cnt - p0, 16);
    check("counter_wrap", cnt4, 0);
    drive(0, 0, 1);
    idle(3);

    // Burst of 5 back-to-back pulses
    div = 8'd0; burst_len = 8'd5;
    p0 = pulse_cnt;
    drive(1, 0, 0);
    idle(8);
    #1;
    check("burst5_pulses", pulse_cnt - p0, 5);

    // Single step, then step while running
    p0 = pulse_cnt;
    drive(0, 1, 0);
    idle(4);
    #1;
    check("step_pulses", pulse_cnt - p0, 1);
    div = 8'd1; burst_len = 8'd0;
    drive(1, 0, 0);
    drive(0, 1, 0);
    idle(4);
    drive(0, 0, 1);
    idle(3);

    // Stop on the terminal-count edge
    div = 8'd2; burst_len = 8'd0;
    p0 = pulse_cnt;
    drive(1, 0, 0);
    idle(8);
    drive(0, 0, 1);
    idle(1);
    #1;
    check("stop_pulses", pulse_cnt - p0, 2);
    idle(3);

    // Mid-run divisor change, then start/step priority
    div = 8'd1; burst_len = 8'd0;
    drive(1, 0, 0);
    div = 8'd7;
    idle(10);
    drive(0, 0, 1);
    idle(2);
    div = 8'd2; burst_len = 8'd3;
    p0 = pulse_cnt;
    drive(1, 1, 0);
    idle(12);
    #1;
    check("priority_pulses", pulse_cnt - p0, 3);

    // Longest legal burst
    div = 8'd0; burst_len = 8'd255;
    p0 = pulse_cnt;
    drive(1, 0, 0);
    idle(258);
    #1;
    check("burst255_pulses", pulse_cnt - p0, 255);

    // Asynchronous reset during the third pulse of a burst
    div = 8'd1; burst_len = 8'd10;
    drive(1, 0, 0);
    idle(6);
    @(posedge clk);
    #2;
    check("pre_reset_t_en", t_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_t_en", t_en, 0);
    check("async_done", done, 0);
    check("async_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    idle(20);
    #1;
    check("post_reset_pulses", pulse_cnt - p0, 0);

    // Randomized segments, each closed by a forced stop
    repeat (15) begin
      repeat (50) begin
        div  = 8'($urandom_range(0, 3));
        pick = $urandom_range(0, 5);
        case (pick)
          0: burst_len = 8'd0;
          1: burst_len = 8'd1;
          2: burst_len = 8'd2;
          3: burst_len = 8'd3;
          4: burst_len = 8'd7;
          default: burst_len = 8'd255;
        endcase
        drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 11) == 0);
      end
      drive(0, 0, 1);
      drive(0, 0, 1);
      idle(3);
    end

    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
